// File: rtl/input_buffer_logic.sv
// rtl/input_buffer_logic.sv - serial byte-to-packet assembler feeding a FWFT packet queue
// Optional IB_FRAME_CHECK_EN: a gap mid-packet drops the partial packet and pulses frame_err.

package input_buffer_logic_pkg;
  typedef logic [3:0][7:0] pkt_t;
endpackage

module input_buffer_logic
  import input_buffer_logic_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] payload_inbound,
  input  logic       put_inbound,
  output logic       ready_inbound,
  output pkt_t       pkt_out,
  output logic       pkt_avail,
  input  logic       read_pkt,
  output logic       full,
  output logic       overflow,
  output logic       frame_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW:0]   DEPTH_CX = (CW + 1)'(DEPTH);

  typedef enum logic {
    IDLE     = 1'b0,
    ASSEMBLE = 1'b1
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [1:0]      byte_cnt;
  pkt_t            asm_pkt;
  pkt_t            commit_pkt;
  logic            capture;
  logic            commit;
  logic            frame_drop;

  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [CW:0]     pending;
  logic            pop;
  logic            push;
  logic            drop;
  pkt_t            mem [DEPTH];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (put_inbound) state_nxt = ASSEMBLE;
      end
      ASSEMBLE: begin
        if (commit) state_nxt = IDLE;
`ifdef IB_FRAME_CHECK_EN
        if (!put_inbound) state_nxt = IDLE;
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    capture    = 1'b0;
    commit     = 1'b0;
    frame_drop = 1'b0;
    case (state)
      IDLE: begin
        capture = put_inbound;
      end
      ASSEMBLE: begin
        capture = put_inbound;
        commit  = put_inbound && (byte_cnt == 2'd3);
`ifdef IB_FRAME_CHECK_EN
        frame_drop = !put_inbound;
`endif
      end
      default: ;
    endcase
  end

  // The fourth byte bypasses the assembly register so the packet commits on the same edge.
  always_comb begin
    commit_pkt    = asm_pkt;
    commit_pkt[0] = payload_inbound;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      byte_cnt  <= 2'd0;
      asm_pkt   <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= frame_drop;
      if (commit || frame_drop) begin
        byte_cnt <= 2'd0;
        asm_pkt  <= '0;
      end else if (capture) begin
        asm_pkt[2'd3 - byte_cnt] <= payload_inbound;
        byte_cnt                 <= byte_cnt + 2'd1;
      end
    end
  end

  assign pkt_avail = (count != '0);
  assign full      = (count == DEPTH_C);
  assign pop       = read_pkt && pkt_avail;
  assign push      = commit && (!full || pop);
  assign drop      = commit && full && !pop;

  assign pending       = {1'b0, count} + {{CW{1'b0}}, (state == ASSEMBLE)};
  assign ready_inbound = (pending < DEPTH_CX);

  // DEPTH is a power of two, so plain increments wrap DEPTH-1 back to 0.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= drop;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= commit_pkt;
  end

  assign pkt_out = pkt_avail ? mem[rd_ptr] : '0;

endmodule

// File: doc/input_buffer_logic.md
INPUT_BUFFER_LOGIC -- requirements
Module: input_buffer_logic

Interface
REQ-001 SHALL have parameter DEPTH, default 4, packet-queue depth in packets (power of two, at least 2).
REQ-002 SHALL have port clock, input, 1 bit: single clock, all state updates on its rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port payload_inbound, input, 8 bits: serial packet byte.
REQ-005 SHALL have port put_inbound, input, 1 bit: payload_inbound valid this cycle.
REQ-006 SHALL have port ready_inbound, output, 1 bit: room exists to accept one whole packet.
REQ-007 SHALL have port pkt_out, output, pkt_t (4x8 = 32 bits): head-of-queue packet.
REQ-008 SHALL have port pkt_avail, output, 1 bit: queue non-empty, pkt_out valid.
REQ-009 SHALL have port read_pkt, input, 1 bit: consumer pops the head packet.
REQ-010 SHALL have port full, output, 1 bit: queue holds DEPTH packets.
REQ-011 SHALL have port overflow, output, 1 bit: one-cycle pulse when a completed packet is dropped.
REQ-012 SHALL have port frame_err, output, 1 bit: one-cycle pulse when a partial packet is discarded.

Function
REQ-013 SHALL assemble 4 bytes per packet, most significant byte first: first byte to pkt[3], last byte to pkt[0].
REQ-014 SHALL run an assembler FSM with states IDLE (0 bytes held) and ASSEMBLE (1-3 bytes held, tracked by 2-bit byte_cnt).
REQ-015 SHALL move IDLE->ASSEMBLE when put_inbound=1, capturing the byte into pkt[3].
REQ-016 SHALL capture the byte in ASSEMBLE when put_inbound=1 and increment byte_cnt; on the 4th byte SHALL commit the packet to the queue on that same edge and return to IDLE.
REQ-017 SHALL assert pkt_avail in the cycle following the edge that captured the 4th byte, given an empty queue (1-cycle latency).
REQ-018 SHALL present pkt_out first-word-fall-through from queue storage; pkt_out SHALL be 0 when the queue is empty.
REQ-019 SHALL pop the head packet on a rising edge when read_pkt=1 and pkt_avail=1; read_pkt with pkt_avail=0 SHALL be ignored.
REQ-020 SHALL use circular read/write pointers that wrap from DEPTH-1 to 0, plus an occupancy count of width clog2(DEPTH)+1.
REQ-021 SHALL, on a simultaneous commit and pop, perform both; when full, the pop frees the slot and the commit SHALL be accepted with full remaining 1.
REQ-022 SHALL, on a commit with the queue full and no pop, drop the packet, leave the queue unchanged, and pulse overflow for 1 cycle.
REQ-023 SHALL drive ready_inbound = (count + (state==ASSEMBLE ? 1 : 0)) < DEPTH, registered-free combinational from state.
REQ-024 SHALL drive full = (count == DEPTH) and pkt_avail = (count != 0).

Reset
REQ-025 SHALL, on reset_n=0 and regardless of clock, clear state to IDLE, byte_cnt, pointers, count, and the assembly register to 0.
REQ-026 SHALL output after reset: pkt_avail=0, full=0, ready_inbound=1, pkt_out=0, overflow=0, frame_err=0.
REQ-027 SHALL discard a packet partially assembled when reset asserts, with no frame_err pulse.

Configuration
REQ-028 SHALL use macro IB_FRAME_CHECK_EN: when defined, put_inbound=0 in ASSEMBLE discards the partial packet, returns to IDLE, and pulses frame_err for 1 cycle.
REQ-029 SHALL, when IB_FRAME_CHECK_EN is undefined, hold bytes and stay in ASSEMBLE across gaps until the 4th byte arrives, with frame_err tied to 0.

Verification
REQ-030 SHALL cover: bytes DE,AD,BE,EF on 4 consecutive cycles -> pkt_out=0xDEADBEEF with pkt_avail=1 the next cycle; read_pkt=1 -> pkt_avail=0.
REQ-031 SHALL cover: DEPTH=4, 4 packets 0x00000001..0x00000004 with no reads -> full=1 and ready_inbound=0; reads pop 1,2,3,4 in order.
REQ-032 SHALL cover: 5th packet 0x55555555 sent while full with no read -> overflow pulses 1 cycle and the queue still pops 1..4.
REQ-033 SHALL cover: queue full with read_pkt=1 on the 4th byte of 0xA5A5A5A5 -> packet accepted, full stays 1, 0xA5A5A5A5 pops last.
REQ-034 SHALL cover: bytes 11,22 then a 1-cycle gap then 33,44 -> with macro, frame_err pulses and no packet forms; without macro, pkt_out=0x11223344.
REQ-035 SHALL cover: reset_n asserted after 2 bytes, then 4 bytes 01,02,03,04 -> pkt_out=0x01020304, with no stale bytes.
